// File: rtl/dna_job_ctrl.sv
// rtl/dna_job_ctrl.sv - job sequencer for the DNA systolic aligner
// Runs one job per command: clear, arm, run with beat/watchdog counting, then report status.
module dna_job_ctrl #(
   parameter int RST_CYCLES     = 2,
   parameter int TIMEOUT        = 1048576,
   parameter int BEAT_W         = 16,
   parameter int MAX_ADDR_WIDTH = 6
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [6:0]        cmd_addr_width,
   input  logic [2:0]        cmd_match,
   input  logic [2:0]        cmd_mismatch,
   input  logic [2:0]        cmd_gap,
   input  logic              abort_i,
   output logic              dna_rst_o,
   output logic              dna_start_o,
   output logic [6:0]        dna_addr_width_o,
   output logic [2:0]        dna_match_o,
   output logic [2:0]        dna_mismatch_o,
   output logic [2:0]        dna_gap_o,
   input  logic              dna_en_i,
   input  logic              dna_w_matrix_i,
   input  logic              dna_ref_empty_i,
   input  logic              dna_matrix_full_i,
   output logic              sts_valid,
   input  logic              sts_ready,
   output logic [1:0]        sts_code,
   output logic [BEAT_W-1:0] sts_beats,
   output logic              busy_o
);

   typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_ARM, S_RUN, S_REPORT} state_e;

   localparam int CNT_W = $clog2(RST_CYCLES + 1);
   localparam int WD_W  = $clog2(TIMEOUT + 1);

   localparam logic [1:0] CODE_REF_DONE = 2'd0;
   localparam logic [1:0] CODE_FULL     = 2'd1;
   localparam logic [1:0] CODE_ABORT    = 2'd2;
   localparam logic [1:0] CODE_CFG_ERR  = 2'd3;

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  clr_q, clr_d;
   logic [WD_W-1:0]   wd_q, wd_d;
   logic [BEAT_W-1:0] beats_q, beats_d;
   logic [1:0]        code_q, code_d;
   logic [6:0]        aw_q, aw_d;
   logic [2:0]        match_q, match_d;
   logic [2:0]        mismatch_q, mismatch_d;
   logic [2:0]        gap_q, gap_d;
   logic              accept;
   logic              unused_en;

   assign unused_en = dna_en_i;
   assign accept    = cmd_valid & cmd_ready;

   always_comb begin
      state_d    = state_q;
      clr_d      = clr_q;
      wd_d       = wd_q;
      beats_d    = beats_q;
      code_d     = code_q;
      aw_d       = aw_q;
      match_d    = match_q;
      mismatch_d = mismatch_q;
      gap_d      = gap_q;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               aw_d       = cmd_addr_width;
               match_d    = cmd_match;
               mismatch_d = cmd_mismatch;
               gap_d      = cmd_gap;
               beats_d    = '0;
               clr_d      = '0;
               if (cmd_addr_width > 7'(MAX_ADDR_WIDTH)) begin
                  state_d = S_REPORT;
                  code_d  = CODE_CFG_ERR;
               end else begin
                  state_d = S_CLEAR;
               end
            end
         end
         S_CLEAR: begin
            if (abort_i) begin
               state_d = S_REPORT;
               code_d  = CODE_ABORT;
            end else if (clr_q == CNT_W'(RST_CYCLES - 1)) begin
               state_d = S_ARM;
            end else begin
               clr_d = clr_q + 1'b1;
            end
         end
         S_ARM: begin
            wd_d = '0;
            if (abort_i) begin
               state_d = S_REPORT;
               code_d  = CODE_ABORT;
            end else begin
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            // A beat in the exit cycle still counts, so count before deciding to leave.
            if (dna_w_matrix_i) begin
               wd_d = '0;
               if (beats_q != '1) beats_d = beats_q + 1'b1;
            end else begin
               wd_d = wd_q + 1'b1;
            end
            if (dna_matrix_full_i) begin
               state_d = S_REPORT;
               code_d  = CODE_FULL;
            end else if (dna_ref_empty_i) begin
               state_d = S_REPORT;
               code_d  = CODE_REF_DONE;
            end else if (abort_i || wd_q == WD_W'(TIMEOUT - 1)) begin
               state_d = S_REPORT;
               code_d  = CODE_ABORT;
            end
         end
         S_REPORT: begin
            if (sts_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= S_IDLE;
         clr_q      <= '0;
         wd_q       <= '0;
         beats_q    <= '0;
         code_q     <= CODE_REF_DONE;
         aw_q       <= '0;
         match_q    <= '0;
         mismatch_q <= '0;
         gap_q      <= '0;
      end else begin
         state_q    <= state_d;
         clr_q      <= clr_d;
         wd_q       <= wd_d;
         beats_q    <= beats_d;
         code_q     <= code_d;
         aw_q       <= aw_d;
         match_q    <= match_d;
         mismatch_q <= mismatch_d;
         gap_q      <= gap_d;
      end
   end

   // Every handshake/control output is a pure decode of the state register.
   assign cmd_ready        = (state_q == S_IDLE);
   assign dna_rst_o        = !((state_q == S_ARM) || (state_q == S_RUN));
   assign dna_start_o      = (state_q == S_ARM);
   assign busy_o           = (state_q == S_CLEAR) || (state_q == S_ARM) || (state_q == S_RUN);
   assign sts_valid        = (state_q == S_REPORT);
   assign sts_code         = code_q;
   assign sts_beats        = beats_q;
   assign dna_addr_width_o = aw_q;
   assign dna_match_o      = match_q;
   assign dna_mismatch_o   = mismatch_q;
   assign dna_gap_o        = gap_q;

endmodule

// File: tb/tb_dna_job_ctrl.sv
// tb/tb_dna_job_ctrl.sv - scoreboard bench for dna_job_ctrl
// Jobs are planned per RUN cycle; the expected status comes from a cycles-since-last-beat model.
module tb_dna_job_ctrl;
   localparam int RST_CYCLES = 2;
   localparam int TIMEOUT    = 16;
   localparam int BEAT_W     = 6;
   localparam int MAX_AW     = 6;
   localparam int N          = 128;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              cmd_valid = 1'b0;
   logic              cmd_ready;
   logic [6:0]        cmd_addr_width = '0;
   logic [2:0]        cmd_match = '0, cmd_mismatch = '0, cmd_gap = '0;
   logic              abort_i = 1'b0;
   logic              dna_rst_o, dna_start_o;
   logic [6:0]        dna_addr_width_o;
   logic [2:0]        dna_match_o, dna_mismatch_o, dna_gap_o;
   logic              dna_en_i = 1'b0;
   logic              dna_w_matrix_i = 1'b0, dna_ref_empty_i = 1'b0, dna_matrix_full_i = 1'b0;
   logic              sts_valid;
   logic              sts_ready = 1'b0;
   logic [1:0]        sts_code;
   logic [BEAT_W-1:0] sts_beats;
   logic              busy_o;

   dna_job_ctrl #(.RST_CYCLES(RST_CYCLES), .TIMEOUT(TIMEOUT), .BEAT_W(BEAT_W),
                  .MAX_ADDR_WIDTH(MAX_AW)) dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_addr_width(cmd_addr_width), .cmd_match(cmd_match), .cmd_mismatch(cmd_mismatch),
      .cmd_gap(cmd_gap), .abort_i(abort_i), .dna_rst_o(dna_rst_o), .dna_start_o(dna_start_o),
      .dna_addr_width_o(dna_addr_width_o), .dna_match_o(dna_match_o),
      .dna_mismatch_o(dna_mismatch_o), .dna_gap_o(dna_gap_o), .dna_en_i(dna_en_i),
      .dna_w_matrix_i(dna_w_matrix_i), .dna_ref_empty_i(dna_ref_empty_i),
      .dna_matrix_full_i(dna_matrix_full_i), .sts_valid(sts_valid), .sts_ready(sts_ready),
      .sts_code(sts_code), .sts_beats(sts_beats), .busy_o(busy_o));

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {int code; int beats;} exp_t;
   exp_t sb_q[$];

   bit w_pl[N], f_pl[N], e_pl[N], a_pl[N];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      if (rst && sts_valid && sts_ready) begin
         exp_t x;
         if (sb_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL sts_unexpected: got code %0d beats %0d with no job outstanding",
                     sts_code, sts_beats);
         end else begin
            x = sb_q.pop_front();
            check("sts_code", 32'(sts_code), x.code);
            check("sts_beats", 32'(sts_beats), x.beats);
         end
      end
   end

   task automatic clear_plan();
      for (int k = 0; k < N; k++) begin
         w_pl[k] = 0; f_pl[k] = 0; e_pl[k] = 0; a_pl[k] = 0;
      end
      e_pl[N-1] = 1;
   endtask

   // Watchdog expressed as idle cycles since the last beat (or since start).
   task automatic model(output int e, output int code, output int beats);
      int idle = 0;
      int cnt  = 0;
      e = N - 1;
      for (int k = 0; k < N; k++) begin
         if (w_pl[k]) cnt++;
         if (f_pl[k] || e_pl[k] || a_pl[k] || idle == TIMEOUT - 1) begin
            e = k;
            break;
         end
         idle = w_pl[k] ? 0 : idle + 1;
      end
      code  = f_pl[e] ? 1 : (e_pl[e] ? 0 : 2);
      beats = (cnt > (1 << BEAT_W) - 1) ? (1 << BEAT_W) - 1 : cnt;
   endtask

   task automatic issue(input logic [6:0] aw, input logic [2:0] m, input logic [2:0] mm,
                        input logic [2:0] g, output int acc);
      int t = 0;
      cmd_addr_width = aw; cmd_match = m; cmd_mismatch = mm; cmd_gap = g;
      cmd_valid = 1'b1;
      while (!cmd_ready && t < 50) begin tick(); t++; end
      check("cmd_ready_wait", 32'(cmd_ready), 1);
      tick();
      acc = cyc;
      cmd_valid = 1'b0;
      cmd_addr_width = 7'($urandom); cmd_match = 3'($urandom);
      cmd_mismatch = 3'($urandom); cmd_gap = 3'($urandom);
      check("cfg_addr_width", 32'(dna_addr_width_o), 32'(aw));
      check("cfg_match", 32'(dna_match_o), 32'(m));
      check("cfg_mismatch", 32'(dna_mismatch_o), 32'(mm));
      check("cfg_gap", 32'(dna_gap_o), 32'(g));
   endtask

   task automatic drain(input int hold, input int code);
      for (int i = 0; i < hold; i++) begin
         cmd_valid = 1'b1;
         tick();
         check("hold_sts_valid", 32'(sts_valid), 1);
         check("hold_sts_code", 32'(sts_code), code);
         check("hold_cmd_ready", 32'(cmd_ready), 0);
      end
      cmd_valid = 1'b0;
      check("sts_valid_before_ready", 32'(sts_valid), 1);
      sts_ready = 1'b1;
      tick();
      sts_ready = 1'b0;
      check("sts_valid_after_ready", 32'(sts_valid), 0);
      check("cmd_ready_after_ready", 32'(cmd_ready), 1);
   endtask

   task automatic wait_start(input int acc);
      int t = 0;
      while (!dna_start_o && t < 20) begin tick(); t++; end
      check("start_latency", 32'(cyc - acc), RST_CYCLES);
      check("aligner_released", 32'(dna_rst_o), 0);
   endtask

   task automatic run_job(input logic [6:0] aw, input logic [2:0] m, input logic [2:0] mm,
                          input logic [2:0] g, input int hold);
      int acc, e, code, beats, k;
      exp_t x;
      if (aw > MAX_AW) begin
         x.code = 3; x.beats = 0;
         sb_q.push_back(x);
         issue(aw, m, mm, g, acc);
         check("cfgerr_sts_valid", 32'(sts_valid), 1);
         check("cfgerr_dna_rst", 32'(dna_rst_o), 1);
         check("cfgerr_no_start", 32'(dna_start_o), 0);
         drain(hold, 3);
         return;
      end
      model(e, code, beats);
      x.code = code; x.beats = beats;
      sb_q.push_back(x);
      issue(aw, m, mm, g, acc);
      wait_start(acc);
      tick();
      check("start_single_pulse", 32'(dna_start_o), 0);
      k = 0;
      while (k < N && !sts_valid) begin
         dna_w_matrix_i = w_pl[k]; dna_matrix_full_i = f_pl[k];
         dna_ref_empty_i = e_pl[k]; abort_i = a_pl[k];
         tick();
         k++;
      end
      dna_w_matrix_i = 0; dna_matrix_full_i = 0; dna_ref_empty_i = 0; abort_i = 0;
      check("exit_latency", 32'(k), 32'(e + 1));
      check("report_dna_rst", 32'(dna_rst_o), 1);
      check("report_busy", 32'(busy_o), 0);
      drain(hold, code);
   endtask

   initial begin
      int acc;
      exp_t x;
      repeat (2) tick();
      check("rst_dna_rst", 32'(dna_rst_o), 1);
      check("rst_start", 32'(dna_start_o), 0);
      check("rst_sts_valid", 32'(sts_valid), 0);
      check("rst_sts_code", 32'(sts_code), 0);
      check("rst_sts_beats", 32'(sts_beats), 0);
      check("rst_busy", 32'(busy_o), 0);
      check("rst_cfg_aw", 32'(dna_addr_width_o), 0);
      rst = 1'b1;
      tick();
      check("rst_cmd_ready", 32'(cmd_ready), 1);

      // abort while idle has no effect
      abort_i = 1'b1;
      repeat (3) tick();
      check("idle_abort_ignored", 32'(sts_valid), 0);
      abort_i = 1'b0;

      // normal job: 48 beats then ref_empty
      clear_plan();
      for (int k = 0; k < 48; k++) w_pl[k] = 1;
      e_pl[48] = 1;
      run_job(7'd2, 3'd2, 3'd1, 3'd1, 0);

      // simultaneous completion inputs: matrix_full wins, beat counted
      clear_plan();
      for (int k = 0; k < 6; k++) w_pl[k] = 1;
      f_pl[5] = 1; e_pl[5] = 1; a_pl[5] = 1;
      run_job(7'd4, 3'd3, 3'd2, 3'd1, 1);

      // config error at the boundary above MAX_ADDR_WIDTH
      run_job(7'd7, 3'd1, 3'd1, 3'd1, 0);
      // largest legal width
      clear_plan();
      w_pl[0] = 1; e_pl[3] = 1;
      run_job(7'd6, 3'd1, 3'd1, 3'd1, 0);

      // watchdog with no beats, then with one beat at RUN cycle 10
      clear_plan();
      run_job(7'd3, 3'd1, 3'd2, 3'd3, 0);
      clear_plan();
      w_pl[10] = 1;
      run_job(7'd3, 3'd1, 3'd2, 3'd3, 0);

      // beat counter saturation
      clear_plan();
      for (int k = 0; k < 80; k++) w_pl[k] = 1;
      e_pl[80] = 1;
      run_job(7'd5, 3'd7, 3'd7, 3'd7, 2);

      // status backpressure for 20 cycles with a pending command
      clear_plan();
      w_pl[0] = 1; w_pl[1] = 1; w_pl[2] = 1; e_pl[4] = 1;
      run_job(7'd1, 3'd2, 3'd2, 3'd2, 20);

      // abort in CLEAR
      x.code = 2; x.beats = 0;
      sb_q.push_back(x);
      issue(7'd2, 3'd1, 3'd1, 3'd1, acc);
      abort_i = 1'b1;
      tick();
      abort_i = 1'b0;
      check("clear_abort_sts", 32'(sts_valid), 1);
      check("clear_abort_latency", 32'(cyc - acc), 1);
      drain(0, 2);

      // abort in ARM
      sb_q.push_back(x);
      issue(7'd2, 3'd1, 3'd1, 3'd1, acc);
      wait_start(acc);
      abort_i = 1'b1;
      tick();
      abort_i = 1'b0;
      check("arm_abort_sts", 32'(sts_valid), 1);
      drain(0, 2);

      // reset mid-RUN abandons the job silently
      issue(7'd2, 3'd1, 3'd1, 3'd1, acc);
      wait_start(acc);
      tick();
      dna_w_matrix_i = 1'b1;
      repeat (3) tick();
      dna_w_matrix_i = 1'b0;
      #2 rst = 1'b0;
      #1;
      check("midrun_rst_dna_rst", 32'(dna_rst_o), 1);
      check("midrun_rst_sts_valid", 32'(sts_valid), 0);
      check("midrun_rst_busy", 32'(busy_o), 0);
      check("midrun_rst_beats", 32'(sts_beats), 0);
      tick();
      rst = 1'b1;
      repeat (2) tick();
      check("midrun_rst_cmd_ready", 32'(cmd_ready), 1);
      check("midrun_rst_no_sts", 32'(sts_valid), 0);

      // randomized jobs
      for (int j = 0; j < 16; j++) begin
         int p;
         logic [6:0] aw;
         aw = ($urandom % 6 == 0) ? 7'(7 + $urandom % 121) : 7'($urandom % 7);
         p = $urandom % 5;
         clear_plan();
         for (int k = 0; k < N - 1; k++) begin
            w_pl[k] = ($urandom % 4) < p;
            f_pl[k] = ($urandom % 60) == 0;
            e_pl[k] = ($urandom % 50) == 0;
            a_pl[k] = ($urandom % 70) == 0;
         end
         run_job(aw, 3'($urandom), 3'($urandom), 3'($urandom), $urandom % 4);
      end

      repeat (2) tick();
      check("scoreboard_empty", 32'(sb_q.size()), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
